// File: rtl/mmio_responder_pkg.sv
// Shared constants for the MMIO responder: register offsets, STATUS layout, widths.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned LED_W  = 16;

  localparam logic [1:0] LED_OFS  = 2'd0;
  localparam logic [1:0] DBG_OFS  = 2'd1;
  localparam logic [1:0] STAT_OFS = 2'd2;
  localparam logic [1:0] CYC_OFS  = 2'd3;

  localparam int unsigned OVF_BIT   = 8;
  localparam int unsigned FULL_BIT  = 4;
  localparam int unsigned EMPTY_BIT = 3;
  localparam int unsigned HALT_BIT  = 0;

  // Assemble the STATUS read word from its fields.
  function automatic logic [DATA_W-1:0] status_word(input logic ovf, input logic full,
                                                    input logic empty, input logic [2:0] cnt);
    logic [DATA_W-1:0] w;
    w            = '0;
    w[OVF_BIT]   = ovf;
    w[FULL_BIT]  = full;
    w[EMPTY_BIT] = empty;
    w[2:0]       = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Debug-output stream: FIFO head word with valid/ready handshake.
interface mmio_responder_if;

  logic [mmio_pkg::DATA_W-1:0] Dbg_Data;
  logic                        Dbg_Valid;
  logic                        Dbg_Ready;

  modport master (output Dbg_Data, output Dbg_Valid, input Dbg_Ready);
  modport slave  (input Dbg_Data, input Dbg_Valid, output Dbg_Ready);

endinterface

// File: rtl/mmio_responder_dbg_fifo.sv
// Small falling-edge FIFO feeding the debug stream; head is the oldest word.
module dbg_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; contents cleared on reset so head reads 0.
  always_ff @(negedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder claiming four word addresses: LED, debug FIFO, status, cycle counter.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE  = 7'h7C,
  parameter int unsigned       DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus,
  output logic              Sel,
  output logic [LED_W-1:0]  LED,
  output logic              Halt,
  mmio_responder_if.master  dbg
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic              wr_en;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              ovf;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] cycle;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] data_out;

  assign Sel     = CS & (ADDR[6:2] == BASE[6:2]);
  assign wr_en   = Sel & WE;
  assign Mem_Bus = (Sel & ~WE) ? data_out : 'z;

  assign push          = wr_en & (ADDR[1:0] == DBG_OFS);
  assign pop           = dbg.Dbg_Valid & dbg.Dbg_Ready;
  assign dbg.Dbg_Valid = ~empty;

  dbg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (Mem_Bus),
    .pop       (pop),
    .head      (dbg.Dbg_Data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Read mux over the pre-edge register values.
  always_comb begin
    rd_mux = '0;
    case (ADDR[1:0])
      LED_OFS:  rd_mux = DATA_W'(LED);
      DBG_OFS:  rd_mux = '0;
      STAT_OFS: rd_mux = status_word(ovf, full, empty, 3'(count));
      CYC_OFS:  rd_mux = cycle;
      default:  rd_mux = '0;
    endcase
  end

  // Register file, cycle counter, halt latch and read-data register.
  always_ff @(negedge CLK) begin
    if (RST) begin
      LED      <= '0;
      Halt     <= 1'b0;
      ovf      <= 1'b0;
      cycle    <= '0;
      data_out <= '0;
    end else begin
      data_out <= rd_mux;
      if (!Halt) cycle <= cycle + DATA_W'(1);
      if (wr_en && ADDR[1:0] == LED_OFS) LED <= Mem_Bus[LED_W-1:0];
      if (wr_en && ADDR[1:0] == CYC_OFS && Mem_Bus[HALT_BIT]) Halt <= 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
      else if (wr_en && ADDR[1:0] == STAT_OFS && Mem_Bus[OVF_BIT]) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Randomized bench for mmio_responder against a queue-based reference model.
module tb_mmio_responder;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        we;
  logic [6:0]  addr;
  wire  [31:0] mem_bus;
  logic        sel;
  logic [15:0] led;
  logic        halt;
  logic        tb_drv;
  logic [31:0] tb_wdata;
  logic [31:0] rd_last;

  int n_chk;
  int n_bad;

  // Reference model state
  logic [15:0] m_led;
  bit          m_halt;
  bit          m_ovf;
  logic [31:0] m_cyc;
  logic [31:0] m_q[$];

  mmio_responder_if dbg_if ();

  assign mem_bus = tb_drv ? tb_wdata : 'z;

  mmio_responder #(.BASE(7'h7C), .DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .RST     (rst),
    .CS      (cs),
    .WE      (we),
    .ADDR    (addr),
    .Mem_Bus (mem_bus),
    .Sel     (sel),
    .LED     (led),
    .Halt    (halt),
    .dbg     (dbg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] ofs);
    logic [31:0] st;
    case (ofs)
      2'd0: return {16'h0, m_led};
      2'd2: begin
        st = (32'(m_ovf) << 8) | (32'(m_q.size() == DEPTH) << 4) |
             (32'(m_q.size() == 0) << 3) | 32'(m_q.size());
        return st;
      end
      2'd3: return m_cyc;
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive after rising edge, model and check around the falling edge.
  task automatic step(input bit r, input bit c, input bit w, input logic [6:0] a,
                      input logic [31:0] wd, input bit ready);
    bit          claimed;
    bit          rd;
    bit          pop_m;
    bit          was_full;
    logic [31:0] exp_rd;
    @(posedge clk);
    rst      = r;
    cs       = c;
    we       = w;
    addr     = a;
    tb_drv   = c & w;
    tb_wdata = wd;
    dbg_if.Dbg_Ready = ready;
    claimed = c && (a[6:2] == 5'h1F);
    rd      = claimed && !w;
    exp_rd  = model_read(a[1:0]);
    #1 chk("sel", 32'(sel), 32'(claimed));
    @(negedge clk);
    if (r) begin
      m_led = '0; m_halt = 0; m_ovf = 0; m_cyc = '0; m_q.delete(); exp_rd = '0;
    end else begin
      pop_m    = (m_q.size() != 0) && ready;
      was_full = (m_q.size() == DEPTH);
      if (!m_halt) m_cyc = m_cyc + 32'd1;
      if (pop_m) void'(m_q.pop_front());
      if (claimed && w) begin
        case (a[1:0])
          2'd0: m_led = wd[15:0];
          2'd1: if (was_full && !pop_m) m_ovf = 1; else m_q.push_back(wd);
          2'd2: if (wd[8]) m_ovf = 0;
          default: if (wd[0]) m_halt = 1;
        endcase
      end
    end
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("halt", 32'(halt), 32'(m_halt));
    chk("valid", 32'(dbg_if.Dbg_Valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("head", dbg_if.Dbg_Data, m_q[0]);
    if (rd) begin
      rd_last = mem_bus;
      chk("rdata", mem_bus, exp_rd);
    end
  endtask

  task automatic idle(input bit ready);
    step(0, 0, 0, 7'h00, 32'h0, ready);
  endtask

  logic [31:0] c1;
  logic [31:0] c2;

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 0; cs = 0; we = 0; addr = '0; tb_drv = 0; tb_wdata = '0; rd_last = '0;
    dbg_if.Dbg_Ready = 0;
    m_led = '0; m_halt = 0; m_ovf = 0; m_cyc = '0;

    // Reset state
    step(1, 0, 0, 7'h00, 32'h0, 0);
    chk("rst_data", dbg_if.Dbg_Data, 32'h0);
    step(0, 1, 0, 7'h7E, 32'h0, 0);
    chk("rst_status", rd_last, 32'h008);

    // LED register
    step(0, 1, 1, 7'h7C, 32'h0001ABCD, 0);
    step(0, 1, 0, 7'h7C, 32'h0, 0);
    chk("led_val", 32'(led), 32'h0000ABCD);
    chk("led_rd", rd_last, 32'h0000ABCD);

    // FIFO fill with overflow
    for (int i = 1; i <= 5; i++) step(0, 1, 1, 7'h7D, 32'(i * 'h11), 0);
    step(0, 1, 0, 7'h7E, 32'h0, 0);
    chk("fill_status", rd_last, 32'h114);
    chk("fill_head", dbg_if.Dbg_Data, 32'h11);

    // Drain
    for (int i = 0; i < 4; i++) idle(1);
    chk("drain_valid", 32'(dbg_if.Dbg_Valid), 32'h0);
    step(0, 1, 0, 7'h7E, 32'h0, 1);
    chk("drain_status", rd_last, 32'h108);
    step(0, 1, 1, 7'h7E, 32'h100, 1);
    step(0, 1, 0, 7'h7E, 32'h0, 1);
    chk("ovf_clear", rd_last, 32'h008);

    // Simultaneous push and pop while full
    for (int i = 1; i <= 4; i++) step(0, 1, 1, 7'h7D, 32'(i), 0);
    step(0, 1, 1, 7'h7D, 32'h66, 1);
    step(0, 1, 0, 7'h7E, 32'h0, 0);
    chk("pp_status", rd_last, 32'h014);
    for (int i = 0; i < 3; i++) idle(1);
    chk("pp_last", dbg_if.Dbg_Data, 32'h66);
    idle(1);

    // Cycle counter and halt
    step(0, 1, 0, 7'h7F, 32'h0, 0); c1 = rd_last;
    step(0, 1, 0, 7'h7F, 32'h0, 0); c2 = rd_last;
    chk("cyc_inc", 32'(c2 > c1), 32'h1);
    step(0, 1, 1, 7'h7F, 32'h1, 0);
    step(0, 1, 0, 7'h7F, 32'h0, 0); c1 = rd_last;
    idle(0);
    step(0, 1, 0, 7'h7F, 32'h0, 0); c2 = rd_last;
    chk("cyc_frozen", c2, c1);
    step(0, 1, 1, 7'h7F, 32'h0, 0);
    chk("halt_sticky", 32'(halt), 32'h1);

    // Reset mid-operation with a write in flight
    step(0, 1, 1, 7'h7C, 32'h5A5A, 0);
    step(0, 1, 1, 7'h7D, 32'hDEAD, 0);
    step(1, 1, 1, 7'h7C, 32'h1234, 0);
    chk("rst2_led", 32'(led), 32'h0);
    chk("rst2_halt", 32'(halt), 32'h0);
    chk("rst2_valid", 32'(dbg_if.Dbg_Valid), 32'h0);
    chk("rst2_data", dbg_if.Dbg_Data, 32'h0);
    step(0, 1, 0, 7'h7E, 32'h0, 0);
    chk("rst2_status", rd_last, 32'h008);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [6:0] ra;
      ra = ($urandom_range(0, 3) != 0) ? 7'(7'h7C + $urandom_range(0, 3)) : 7'($urandom);
      step(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom), ra, $urandom,
           ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped I/O responder on the CPU's `CS`/`WE`/`ADDR`/`Mem_Bus` memory bus, placed beside `Memory` inside `Complete_MIPS`.

- Claims the top four word addresses, 0x7C–0x7F.
- Provides four registers: an LED register, a 4-entry debug-output FIFO drained through a valid/ready handshake, a status/control register, and a free-running cycle counter with a halt latch.
- `Sel` is used by the top level to gate `Memory`'s `CS`, so exactly one responder drives the bus.

## Interface
Parameters:
- `BASE`, default 7'h7C: first claimed word address; must be 4-aligned.
- `DEPTH`, default 4: debug FIFO entries (power of two).

Ports:
- `CLK` in 1: system clock. The block acts on the falling edge, identical to `Memory`.
- `RST` in 1: reset, synchronous and active-high.
- `CS` in 1: bus chip select from CPU.
- `WE` in 1: bus write enable from CPU.
- `ADDR` in 7: bus word address.
- `Mem_Bus` inout 32: shared data bus. The block drives it only on its own reads.
- `Sel` out 1: combinational, `CS & (ADDR[6:2] == BASE[6:2])`. The top level drives `Memory` CS with `CS & ~Sel`.
- `LED` out 16: LED register contents.
- `Halt` out 1: sticky halt request to the CPU.
- `Dbg_Data` out 32: FIFO head word.
- `Dbg_Valid` out 1: FIFO non-empty.
- `Dbg_Ready` in 1: external consumer accepts the head word.

## Operation
Register map, by `ADDR[1:0]`:
- **0 LED**
  - Write: stores `Mem_Bus[15:0]`.
  - Read: returns `{16'b0, LED}`.
- **1 DBG**
  - Write: pushes `Mem_Bus` into the FIFO. If the FIFO is full and no pop occurs on the same edge, the word is dropped and `ovf` is set.
  - Read: returns 0.
- **2 STATUS**
  - Read: returns `{23'b0, ovf[8], 3'b0, full[4], empty[3], count[2:0]}`.
  - Write: `Mem_Bus[8]=1` clears `ovf`. All other bits are ignored.
- **3 CYCLE**
  - Read: returns the 32-bit cycle counter.
  - Write: `Mem_Bus[0]=1` sets `Halt`. Writing 0 has no effect.
  - `Halt` clears only on `RST`.

Behaviour rules:
- The bus drive enable is `Sel & ~WE` (combinational), otherwise high-Z. This mirrors `Memory`.
- The cycle counter increments every falling edge while `Halt=0` and freezes while `Halt=1`. It wraps from 0xFFFFFFFF to 0.
- FIFO pop occurs on a falling edge when `Dbg_Valid & Dbg_Ready`.
- **Simultaneous push and pop:**
  - Both take effect and `count` is unchanged.
  - If the FIFO was full, the push is accepted and `ovf` is not set.
  - If the FIFO was empty, there is no pop. The push fills the FIFO and `Dbg_Valid` rises after that edge.
- Pointers are `log2(DEPTH)` bits and wrap naturally. `count` is `log2(DEPTH)+1` bits, range 0..`DEPTH`.
- Unclaimed addresses: the block does nothing and `Sel=0`.

## Timing
- All state updates on the falling edge of `CLK`. `RST` is sampled there too.
- **Reset values:**
  - `LED=0`, `Halt=0`, `ovf=0`, counter 0, FIFO empty.
  - `Dbg_Valid=0`, `Dbg_Data=0`.
  - Read register `data_out=0`.
- **Write:** captured at the falling edge while `CS & WE & Sel`. The new value is visible on outputs immediately after that edge.
- **Read:**
  - `data_out` is registered at every falling edge from the addressed register's pre-edge value.
  - It is valid on `Mem_Bus` for the following rising edge, where the CPU latches it.
  - Latency is a half cycle, matching `Memory`, so the CPU's lw timing is unchanged.
- **STATUS/CYCLE read coincident with a push/pop or count:** returns the pre-edge value.
- `Dbg_Data`/`Dbg_Valid` are registered state. Both change only at falling edges.
- **Reset mid-operation:** the FIFO contents are discarded and `Dbg_Valid` drops at that edge. Any in-flight bus write at that edge is ignored.

## Structure
- Package `mmio_pkg`:
  - Register offsets `LED_OFS`=0, `DBG_OFS`=1, `STAT_OFS`=2, `CYC_OFS`=3.
  - STATUS bit positions (`OVF_BIT`=8, `FULL_BIT`=4, `EMPTY_BIT`=3).
  - `HALT_BIT`=0.
- Sub-module `dbg_fifo`:
  - Parameters: `DEPTH`, width 32.
  - Ports: push/data, pop, head, count, full, empty.
  - Falling-edge clocked with synchronous reset.
- Decode, registers, counter and bus drive live in `mmio_responder`.

## Test plan
- **LED:** sw 0x0001ABCD to 0x7C; lw 0x7C → `LED`=0xABCD, read 0x0000ABCD. `Memory` word 0x7C is unchanged and `Memory` never drives the bus.
- **FIFO fill:** `Dbg_Ready=0`; sw 0x11, 0x22, 0x33, 0x44, 0x55 to 0x7D → STATUS=0x114 (ovf, full, count 4). `Dbg_Data`=0x11.
- **FIFO drain:** `Dbg_Ready=1` → 0x11, 0x22, 0x33, 0x44 on four consecutive falling edges, then `Dbg_Valid`=0. STATUS=0x108; sw 0x100 to 0x7E → STATUS=0x008.
- **Simultaneous push and pop:** FIFO full, `Dbg_Ready=1`, sw 0x66 on the same edge → count stays 4, `ovf` stays 0, 0x66 is output last.
- **Halt:** lw 0x7F twice → second value greater than first. sw 1 to 0x7F → `Halt`=1 and the counter is frozen. sw 0 to 0x7F → `Halt` stays 1.
- **Reset:** `RST` asserted with a non-empty FIFO, `LED`≠0 and `Halt`=1 → after one falling edge all outputs are 0 and STATUS=0x008.
